win_mul_arbiter: RTL and testbench
==================================

# win_mul_arbiter

Round-robin arbiter and sequencer that shares one free-running 8-bit multi-cycle multiplier (`win_mul_8`) among `N_REQ` requesters in the Winograd LeNet datapath. It accepts one operand pair at a time and holds it on the multiplier inputs long enough for any phase of the multiplier's internal 4-state cycle to produce a settled product. It then captures the 16-bit result and returns it tagged with the requester index.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, 2, width of requester index; 2^ID_W >= N_REQ
- `HOLD_CYC`, 8, cycles operands are held on the multiplier before capture (>= 2)
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous abort: drop any in-flight operation, no response
- `req_valid`  in  N_REQ  per-requester operand valid
- `req_a`  in  8*N_REQ  operand A, requester i at bits [8i+7:8i], sign-magnitude
- `req_b`  in  8*N_REQ  operand B, same packing
- `req_ready`  out  N_REQ  one-hot grant; handshake completes when valid & ready
- `mul_a`  out  8  operand A to shared multiplier
- `mul_b`  out  8  operand B to shared multiplier
- `mul_out`  in  16  product from shared multiplier
- `rsp_valid`  out  1  one-cycle result strobe
- `rsp_data`  out  16  captured product, passed unmodified
- `rsp_id`  out  ID_W  index of requester that owns rsp_data
- `busy`  out  1  high while an operation is in flight (state HOLD)

## Operation
- FSM states: IDLE, HOLD.
- IDLE: if any `req_valid`, grant the first valid requester searching upward, with wrap, from `last_grant+1`. `req_ready` is combinational; it is high only in IDLE, only for the winner, and at most one bit at a time.
- On acceptance:
  - latch the winner's A/B and index;
  - set `last_grant` to the winner;
  - load the counter with HOLD_CYC-1;
  - go to HOLD.
- HOLD: `mul_a`/`mul_b` are driven from the latched operands, which are stable for every HOLD cycle. Decrement the counter each cycle. When counter==0:
  - register `mul_out` into `rsp_data`;
  - register the latched index into `rsp_id`;
  - set `rsp_valid` for the next cycle;
  - go to IDLE.
- IDLE drives `mul_a`=`mul_b`=0.
- `rsp_data`/`rsp_id` hold their value until the next capture. `rsp_valid` is high for exactly one cycle per accepted request. There is no back-pressure on responses; consumers must sample on the strobe.
- `clr` (priority below reset, above everything else):
  - FSM goes to IDLE, counter to 0, `rsp_valid` to 0;
  - `last_grant` is kept;
  - no grant is issued in the `clr` cycle.
- Requests deasserted before grant are simply not served. Operand changes after acceptance have no effect.
- The arbiter performs no arithmetic. Sign handling is entirely inside the multiplier.

## Timing
- Reset values:
  - FSM IDLE; `last_grant`=N_REQ-1, so requester 0 wins first;
  - `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `req_ready`=0.
- Accept in cycle T:
  - `mul_a`/`mul_b` valid and `busy`=1 for cycles T+1 .. T+HOLD_CYC;
  - `mul_out` sampled at the end of cycle T+HOLD_CYC;
  - `rsp_valid`=1 in cycle T+1+HOLD_CYC, which is also IDLE, so a new grant may occur in the same cycle.
- Throughput: one operation per HOLD_CYC+1 cycles. Latency from acceptance to response: HOLD_CYC+1 cycles.
- All requesters continuously valid gives grants 0,1,2,3,0,… with no requester starved.
- `rst_n` low mid-HOLD: all outputs return to reset values immediately, asynchronously, and no response is produced.
- `clr` in the capture cycle (counter==0): no capture and no `rsp_valid`.

## Test plan
- **Reset/idle.** Hold `rst_n` low, then release with all `req_valid`=0. Expect all outputs 0 and `busy`=0 for 20 cycles.
- **Single request, stub routing.**
  - Stub: `mul_out`={`mul_a`,`mul_b`}.
  - Stimulus: requester 2 sends A=8'h83, B=8'h05 at T.
  - Expect: `req_ready`=4'b0100 at T; `rsp_valid` only at T+9; `rsp_data`=16'h8305; `rsp_id`=2.
- **Real multiplier.** Use a `win_mul_8` instance with A=8'h03, B=8'h85 (3 × −5). Expect `rsp_data`=16'hFFF1.
- **Round-robin fairness.** All 4 requesters continuously valid with distinct operands. Expect `rsp_id` sequence 0,1,2,3,0,1, with responses every 9 cycles.
- **Abort.** Assert `clr` in the 4th HOLD cycle.
  - Expect: IDLE next cycle, no `rsp_valid`, `busy`=0.
  - The next grant goes to the requester after the aborted one.
- **Async reset mid-operation.** Assert `rst_n` low for 1 cycle during HOLD. Expect no response and requester 0 granted first after release.

Source files
------------

// File: rtl/win_mul_arbiter_if.sv
// Requester/response bundle for win_mul_arbiter.
// The master side drives operands and consumes grants and results. The slave
// side is the arbiter itself.
interface win_mul_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [15:0]        rsp_data;
    logic [ID_W-1:0]    rsp_id;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/win_mul_arbiter.sv
// Round-robin sharing of one free-running multi-cycle 8-bit multiplier.
// The block accepts one operand pair at a time and holds it on the multiplier
// for HOLD_CYC cycles, so that any phase of the multiplier's internal cycle
// has settled. It then captures the product and returns it tagged with the
// index of the requester that owns it.
module win_mul_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    win_mul_arbiter_if.slave    bus,
    output logic [7:0]          mul_a,
    output logic [7:0]          mul_b,
    input  logic [15:0]         mul_out
);

    localparam int CNT_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [7:0]         a_reg;
    logic [7:0]         b_reg;
    logic [ID_W-1:0]    id_reg;
    logic [ID_W-1:0]    last_grant_reg;
    logic               rsp_valid_reg;
    logic [15:0]        rsp_data_reg;
    logic [ID_W-1:0]    rsp_id_reg;

    logic [7:0]         a_arr [N_REQ];
    logic [7:0]         b_arr [N_REQ];
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic               capture;
    int                 cand;

    // Unpack the flat operand buses into per-requester bytes.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.req_a[8*gi +: 8];
        assign b_arr[gi] = bus.req_b[8*gi +: 8];
    end

    // Round-robin search: the first valid requester upward from last_grant+1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(last_grant_reg) + 1 + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // A grant is issued only while idle. No grant is issued while reset or an abort is active.
    assign accept  = rst_n && (state_reg == IDLE) && !clr && grant_found;
    assign capture = (state_reg == HOLD) && (cnt_reg == '0);

    // One-hot ready back to the winning requester.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign bus.req_ready[gi] = accept && (grant_id == ID_W'(gi));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: an abort forces idle. Otherwise the state is held until the countdown expires.
    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept)         state_next = HOLD;
                HOLD:    if (cnt_reg == '0)  state_next = IDLE;
                default:                     state_next = IDLE;
            endcase
        end
    end

    // Operand latch, owner index, round-robin pointer and hold countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= '0;
            last_grant_reg <= ID_W'(N_REQ - 1);
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (accept) begin
            a_reg          <= a_arr[grant_id];
            b_reg          <= b_arr[grant_id];
            id_reg         <= grant_id;
            last_grant_reg <= grant_id;
            cnt_reg        <= CNT_W'(HOLD_CYC - 1);
        end else if ((state_reg == HOLD) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // Capture the settled product on the final hold cycle and strobe it for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else if (clr) begin
            rsp_valid_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= capture;
            if (capture) begin
                rsp_data_reg <= mul_out;
                rsp_id_reg   <= id_reg;
            end
        end
    end

    assign bus.busy      = (state_reg == HOLD);
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign mul_a         = (state_reg == HOLD) ? a_reg : 8'h00;
    assign mul_b         = (state_reg == HOLD) ? b_reg : 8'h00;

endmodule

// File: tb/tb_win_mul_arbiter.sv
// Self-checking bench for win_mul_arbiter.
// The multiplier is modelled in the bench. It is either a routing stub that
// returns {mul_a, mul_b}, or a sign-magnitude multiplier that returns a
// two's-complement product.
module tb_win_mul_arbiter;

    localparam int N_REQ    = 4;
    localparam int ID_W     = 2;
    localparam int HOLD_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_out;
    logic        arith;

    win_mul_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    win_mul_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bus     (bus),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_out (mul_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] smmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] mag;
        mag = 16'(a[6:0]) * 16'(b[6:0]);
        return (a[7] ^ b[7]) ? (16'h0000 - mag) : mag;
    endfunction

    always_comb begin
        mul_out = arith ? smmul(mul_a, mul_b) : {mul_a, mul_b};
    end

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          id;
        logic        arith;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    exp_t sb [$];
    int   rsp_ids [$];
    int   rsp_cycs [$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [3:0] hs;
    int         hid;
    logic [7:0] ea;
    logic [7:0] eb;
    exp_t       e;
    exp_t       got;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push expectations on handshakes and check each response against the queue head.
    always @(negedge clk) begin
        hs = bus.req_ready & bus.req_valid;
        if (hs != 4'b0000) begin
            total++;
            if (!$onehot(hs)) begin
                bad++;
                $display("FAIL onehot: got %b want one bit", hs);
            end
            hid = 0;
            for (int i = 0; i < N_REQ; i++) if (hs[i]) hid = i;
            ea     = bus.req_a[8*hid +: 8];
            eb     = bus.req_b[8*hid +: 8];
            e.id   = 2'(hid);
            e.data = arith ? smmul(ea, eb) : {ea, eb};
            e.cyc  = cyc + HOLD_CYC + 1;
            sb.push_back(e);
        end
        if (bus.rsp_valid) begin
            total++;
            rsp_ids.push_back(int'(bus.rsp_id));
            rsp_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h want no response", bus.rsp_id, bus.rsp_data);
            end else begin
                got = sb.pop_front();
                if (bus.rsp_id !== got.id || bus.rsp_data !== got.data || cyc != got.cyc) begin
                    bad++;
                    $display("FAIL rsp: got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d",
                             bus.rsp_id, bus.rsp_data, cyc, got.id, got.data, got.cyc);
                end else begin
                    $display("rsp id=%0d data=%h cyc=%0d ok", bus.rsp_id, bus.rsp_data, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_all_ops();
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_a[8*i +: 8] = 8'h10 + 8'(i);
            bus.req_b[8*i +: 8] = 8'h20 + 8'(i);
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{id: 2, arith: 1'b0, a: 8'h83, b: 8'h05, exp: 16'h8305};
        vecs[1] = '{id: 0, arith: 1'b0, a: 8'h12, b: 8'h34, exp: 16'h1234};
        vecs[2] = '{id: 3, arith: 1'b0, a: 8'hFF, b: 8'h00, exp: 16'hFF00};
        vecs[3] = '{id: 1, arith: 1'b1, a: 8'h03, b: 8'h85, exp: 16'hFFF1};
        vecs[4] = '{id: 0, arith: 1'b1, a: 8'h85, b: 8'h85, exp: 16'h0019};
        vecs[5] = '{id: 3, arith: 1'b1, a: 8'h7F, b: 8'h7F, exp: 16'h3F01};
        vecs[6] = '{id: 2, arith: 1'b1, a: 8'h80, b: 8'h05, exp: 16'h0000};

        rst_n         = 1'b0;
        clr           = 1'b0;
        arith         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset and idle.
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", 64'({bus.req_ready, mul_a, mul_b, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.busy}), 64'd0);
        end

        // Single requests from the table.
        for (int v = 0; v < 7; v++) begin
            tick();
            arith                       = vecs[v].arith;
            bus.req_a                   = '0;
            bus.req_b                   = '0;
            bus.req_a[8*vecs[v].id +: 8] = vecs[v].a;
            bus.req_b[8*vecs[v].id +: 8] = vecs[v].b;
            bus.req_valid               = 4'(1 << vecs[v].id);
            @(negedge clk);
            check("grant", 64'(bus.req_ready), 64'(1 << vecs[v].id));
            tick();
            bus.req_valid = '0;
            bus.req_a     = ~bus.req_a;
            bus.req_b     = ~bus.req_b;
            @(negedge clk);
            check("hold_ops", 64'({bus.busy, mul_a, mul_b}), 64'({1'b1, vecs[v].a, vecs[v].b}));
            wait_drain(20);
            @(negedge clk);
            check("rsp_hold", 64'({bus.rsp_valid, bus.rsp_data}), 64'({1'b0, vecs[v].exp}));
            $display("vec %0d id=%0d a=%h b=%h exp=%h", v, vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp);
        end

        // Round-robin fairness with every requester continuously valid.
        arith = 1'b0;
        reset_pulse();
        rsp_ids.delete();
        rsp_cycs.delete();
        set_all_ops();
        bus.req_valid = 4'hF;
        for (int i = 0; i < 100; i++) begin
            if (rsp_ids.size() >= 6) break;
            tick();
        end
        check("rr_count", 64'(rsp_ids.size() >= 6), 64'd1);
        bus.req_valid = '0;
        wait_drain(20);
        for (int i = 0; i < 6 && i < rsp_ids.size(); i++) begin
            check("rr_id", 64'(rsp_ids[i]), 64'(i % 4));
            if (i > 0) check("rr_gap", 64'(rsp_cycs[i] - rsp_cycs[i-1]), 64'(HOLD_CYC + 1));
        end

        // Abort in the fourth hold cycle.
        reset_pulse();
        set_all_ops();
        bus.req_valid = 4'hF;
        @(negedge clk);
        check("abort_grant", 64'(bus.req_ready), 64'b0001);
        repeat (4) tick();
        clr = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd1);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("abort_next", 64'({bus.busy, bus.rsp_valid, bus.req_ready}), 64'({1'b0, 1'b0, 4'b0010}));
        tick();
        bus.req_valid = '0;
        wait_drain(20);
        $display("abort sequence done");

        // Abort in the capture cycle, and no grant while clr is high.
        tick();
        bus.req_valid = 4'b1000;
        @(negedge clk);
        check("cap_grant", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = '0;
        repeat (7) tick();
        clr = 1'b1;
        sb.delete();
        tick();
        bus.req_valid = 4'b0001;
        @(negedge clk);
        check("cap_abort", 64'({bus.rsp_valid, bus.busy, bus.req_ready, bus.rsp_data}), 64'({1'b0, 1'b0, 4'b0000, 16'h1121}));
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("post_clr_grant", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        wait_drain(20);
        $display("capture abort sequence done");

        // Asynchronous reset in the middle of an operation.
        tick();
        bus.req_valid = 4'hF;
        @(negedge clk);
        check("async_pre_grant", 64'(bus.req_ready), 64'b0010);
        repeat (3) tick();
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_outputs", 64'({bus.busy, mul_a, mul_b, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id}), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("async_first", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        wait_drain(20);
        repeat (20) tick();
        check("final_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
